// File: rtl/iic_pkg.sv
// Shared types and constants for the I2C register target.
// Bus bit levels are named so drive code reads as sda_oe = ~bit.
package iic_pkg;
  localparam int   BYTE_W = 8;
  localparam logic ACK    = 1'b0;
  localparam logic NACK   = 1'b1;

  typedef enum logic [3:0] {
    IDLE, ADDR, ADDR_ACK, REG, REG_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, IGNORE
  } iic_tgt_state_t;
endpackage

// File: rtl/iic_line_filter.sv
// Async bus line: 2-FF sync, then level changes only after FILTER_LEN equal samples.
// rise/fall pulse for one clk, in the clk after the filtered level moves; no backpressure.
module iic_line_filter #(
  parameter int FILTER_LEN = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic rise,
  output logic fall
);
  localparam int CW = $clog2(FILTER_LEN + 1);

  logic [1:0]    sync;
  logic [CW-1:0] cnt;
  logic          level_d;

  always_ff @(posedge clk) begin
    if (!rst) begin
      sync    <= 2'b11;
      cnt     <= '0;
      level   <= 1'b1;
      level_d <= 1'b1;
    end else begin
      sync    <= {sync[0], raw};
      level_d <= level;
      // Any sample agreeing with the current level restarts the run.
      if (sync[1] == level) begin
        cnt <= '0;
      end else if (cnt == CW'(FILTER_LEN - 1)) begin
        level <= sync[1];
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  assign rise = level & ~level_d;
  assign fall = ~level & level_d;
endmodule

// File: rtl/iic_target.sv
// I2C target exposing an 8-bit register pointer with write strobe and read lookup.
// Read path only when IIC_TARGET_READ_EN is defined; otherwise R/W=1 addresses are NACKed.
module iic_target
  import iic_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR   = 7'b1110110,
  parameter int         FILTER_LEN = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              scl_in,
  input  logic              sda_in,
  output logic              sda_oe,
  output logic              wr_en,
  output logic [BYTE_W-1:0] wr_addr,
  output logic [BYTE_W-1:0] wr_data,
  output logic [BYTE_W-1:0] rd_addr,
  input  logic [BYTE_W-1:0] rd_data,
  output logic              busy
);
`ifdef IIC_TARGET_READ_EN
  localparam logic READ_EN = 1'b1;
`else
  localparam logic READ_EN = 1'b0;
  logic unused_rd_data;
  assign unused_rd_data = ^rd_data;
`endif

  logic scl, scl_rise, scl_fall, sda, sda_rise, sda_fall;
  logic start, stop;

  iic_line_filter #(.FILTER_LEN(FILTER_LEN)) u_scl_filt (
    .clk(clk), .rst(rst), .raw(scl_in), .level(scl), .rise(scl_rise), .fall(scl_fall)
  );
  iic_line_filter #(.FILTER_LEN(FILTER_LEN)) u_sda_filt (
    .clk(clk), .rst(rst), .raw(sda_in), .level(sda), .rise(sda_rise), .fall(sda_fall)
  );

  assign start = sda_fall & scl;
  assign stop  = sda_rise & scl;

  iic_tgt_state_t    state;
  logic [3:0]        bit_cnt;
  logic [BYTE_W-1:0] shreg, ptr, shifted;

  assign shifted = {shreg[BYTE_W-2:0], sda};
  assign rd_addr = ptr;
  assign busy    = state inside {ADDR_ACK, REG, REG_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK};

  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= IDLE;
      bit_cnt <= '0;
      shreg   <= '0;
      ptr     <= '0;
      sda_oe  <= 1'b0;
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
    end else begin
      wr_en <= 1'b0;
      if (start) begin
        state   <= ADDR;
        bit_cnt <= '0;
        sda_oe  <= 1'b0;
      end else if (stop) begin
        state   <= IDLE;
        bit_cnt <= '0;
        sda_oe  <= 1'b0;
      end else begin
        case (state)
          ADDR, REG, WDATA: begin
            if (scl_rise && bit_cnt != 4'd8) begin
              shreg   <= shifted;
              bit_cnt <= bit_cnt + 1'b1;
              if (state == WDATA && bit_cnt == 4'd7) begin
                wr_en   <= 1'b1;
                wr_addr <= ptr;
                wr_data <= shifted;
                ptr     <= ptr + 1'b1;
              end
            end else if (scl_fall && bit_cnt == 4'd8) begin
              bit_cnt <= '0;
              sda_oe  <= ~ACK;
              if (state == REG) begin
                ptr   <= shreg;
                state <= REG_ACK;
              end else if (state == WDATA) begin
                state <= WDATA_ACK;
              end else if (shreg[7:1] == DEV_ADDR && (!shreg[0] || READ_EN)) begin
                state <= ADDR_ACK;
              end else begin
                state  <= IGNORE;
                sda_oe <= ~NACK;
              end
            end
          end
          ADDR_ACK: if (scl_fall) begin
            // shreg[0] still holds the R/W bit here.
            state  <= REG;
            sda_oe <= 1'b0;
`ifdef IIC_TARGET_READ_EN
            if (shreg[0]) begin
              state  <= RDATA;
              shreg  <= rd_data;
              sda_oe <= ~rd_data[BYTE_W-1];
            end
`endif
          end
          REG_ACK, WDATA_ACK: if (scl_fall) begin
            state  <= WDATA;
            sda_oe <= 1'b0;
          end
`ifdef IIC_TARGET_READ_EN
          RDATA: begin
            if (scl_rise) begin
              bit_cnt <= bit_cnt + 1'b1;
            end else if (scl_fall) begin
              if (bit_cnt == 4'd8) begin
                state   <= RDATA_ACK;
                bit_cnt <= '0;
                sda_oe  <= 1'b0;
                ptr     <= ptr + 1'b1;
              end else begin
                shreg  <= {shreg[BYTE_W-2:0], 1'b0};
                sda_oe <= ~shreg[BYTE_W-2];
              end
            end
          end
          RDATA_ACK: begin
            // bit_cnt==1 marks "master acknowledged" until the closing SCL fall.
            if (scl_rise) begin
              if (sda == NACK) state <= IGNORE;
              else             bit_cnt <= 4'd1;
            end else if (scl_fall && bit_cnt == 4'd1) begin
              state   <= RDATA;
              bit_cnt <= '0;
              shreg   <= rd_data;
              sda_oe  <= ~rd_data[BYTE_W-1];
            end
          end
`endif
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_iic_target.sv
// Bench for iic_target: bit-banged I2C master, write scoreboard, table of write transactions.
module tb_iic_target;
  localparam int Q = 12;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       scl_m = 1'b1;
  logic       sda_m = 1'b1;
  logic       sda_line;
  logic       sda_oe, wr_en, busy;
  logic [7:0] wr_addr, wr_data, rd_addr, rd_data;

  assign sda_line = sda_m & ~sda_oe;
  assign rd_data  = rd_addr ^ 8'h7A;

  always #5 clk = ~clk;

  iic_target dut (
    .clk(clk), .rst(rst), .scl_in(scl_m), .sda_in(sda_line), .sda_oe(sda_oe),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .rd_addr(rd_addr),
    .rd_data(rd_data), .busy(busy)
  );

  int          checks = 0;
  int          errors = 0;
  int          oe_cnt = 0;
  logic        wr_prev = 1'b0;
  logic [15:0] exp_q[$];

  typedef struct {
    logic [7:0] dev;
    logic [7:0] rg;
    logic [7:0] d0;
    logic [7:0] d1;
    int         nd;
    logic       ack;
    logic [7:0] rd_after;
  } vec_t;
  vec_t vecs[4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      if (sda_oe) oe_cnt++;
      if (wr_en) begin
        chk("wr_en_one_clk", wr_prev, 0);
        chk("wr_expected", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) chk("wr_addr_data", {wr_addr, wr_data}, exp_q.pop_front());
      end
    end
    wr_prev = wr_en;
  end

  task automatic wq(input int n = 1);
    repeat (n * Q) @(negedge clk);
  endtask

  task automatic do_start();
    wq(); sda_m = 1'b1; wq(); scl_m = 1'b1; wq(); sda_m = 1'b0; wq(); scl_m = 1'b0;
  endtask

  task automatic do_stop();
    wq(); sda_m = 1'b0; wq(); scl_m = 1'b1; wq(); sda_m = 1'b1; wq(2);
  endtask

  task automatic clk_bit(input logic b, output logic s);
    wq(); sda_m = b; wq(); scl_m = 1'b1; wq(); s = sda_line; wq(); scl_m = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) clk_bit(b[i], s);
    clk_bit(1'b1, ack);
  endtask

  task automatic recv_byte(input logic nack, output logic [7:0] b);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      clk_bit(1'b1, s);
      b[i] = s;
    end
    clk_bit(nack, s);
  endtask

  initial begin
    logic       a, s;
    logic [7:0] b;
    int         o;

    vecs[0] = '{8'hEC, 8'h41, 8'h10, 8'h00, 1, 1'b0, 8'h42};
    vecs[1] = '{8'hEC, 8'hFF, 8'hAA, 8'hBB, 2, 1'b0, 8'h01};
    vecs[2] = '{8'hEE, 8'h55, 8'h00, 8'h00, 0, 1'b1, 8'h01};
    vecs[3] = '{8'hEC, 8'h98, 8'h03, 8'hE0, 2, 1'b0, 8'h9A};

    repeat (5) @(negedge clk);
    chk("rst_sda_oe", sda_oe, 0);
    chk("rst_wr_en", wr_en, 0);
    chk("rst_wr_addr", wr_addr, 0);
    chk("rst_wr_data", wr_data, 0);
    chk("rst_rd_addr", rd_addr, 0);
    chk("rst_busy", busy, 0);
    rst = 1'b1;
    wq(2);

    // One-clk low glitch on an idle bus must not register as START.
    sda_m = 1'b0;
    @(negedge clk);
    sda_m = 1'b1;
    wq(2);
    chk("glitch_busy", busy, 0);
    o = oe_cnt;
    send_byte(8'hEC, a);
    chk("glitch_no_ack", a, 1);
    chk("glitch_no_oe", oe_cnt - o, 0);
    do_stop();

    for (int v = 0; v < 4; v++) begin
      o = oe_cnt;
      do_start();
      send_byte(vecs[v].dev, a);
      chk($sformatf("v%0d_addr_ack", v), a, vecs[v].ack);
      if (vecs[v].ack == 1'b0) begin
        chk($sformatf("v%0d_busy_hi", v), busy, 1);
        for (int i = 0; i < vecs[v].nd; i++)
          exp_q.push_back({8'(vecs[v].rg + 8'(i)), (i == 0) ? vecs[v].d0 : vecs[v].d1});
        send_byte(vecs[v].rg, a);
        chk($sformatf("v%0d_reg_ack", v), a, 0);
        for (int i = 0; i < vecs[v].nd; i++) begin
          send_byte((i == 0) ? vecs[v].d0 : vecs[v].d1, a);
          chk($sformatf("v%0d_data%0d_ack", v, i), a, 0);
        end
      end else begin
        send_byte(vecs[v].rg, a);
        chk($sformatf("v%0d_byte_nack", v), a, 1);
        chk($sformatf("v%0d_busy_lo", v), busy, 0);
        chk($sformatf("v%0d_no_oe", v), oe_cnt - o, 0);
      end
      do_stop();
      chk($sformatf("v%0d_idle_busy", v), busy, 0);
      chk($sformatf("v%0d_rd_addr", v), rd_addr, vecs[v].rd_after);
    end

    // Pointer 0x9A, repeated START into a read, master NACKs the byte.
    do_start();
    send_byte(8'hEC, a);
    chk("rd_wr_addr_ack", a, 0);
    do_start();
    send_byte(8'hED, a);
`ifdef IIC_TARGET_READ_EN
    chk("rd_addr_ack", a, 0);
    recv_byte(1'b1, b);
    chk("rd_byte", b, 8'hE0);
    wq();
    chk("rd_released", sda_oe, 0);
    do_stop();
    chk("rd_ptr_after", rd_addr, 8'h9B);
`else
    chk("rd_addr_nack", a, 1);
    chk("rd_busy_lo", busy, 0);
    do_stop();
    chk("rd_ptr_after", rd_addr, 8'h9A);
`endif

    // Reset after 4 bits of a data byte: no write, no ACK for the remainder.
    do_start();
    send_byte(8'hEC, a);
    chk("mid_addr_ack", a, 0);
    send_byte(8'h10, a);
    chk("mid_reg_ack", a, 0);
    for (int i = 7; i >= 4; i--) clk_bit(b[i] & 1'b0 | ((8'h5F >> i) & 1), s);
    wq();
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("mid_rst_sda_oe", sda_oe, 0);
    chk("mid_rst_wr_en", wr_en, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_rd_addr", rd_addr, 0);
    rst = 1'b1;
    for (int i = 3; i >= 0; i--) clk_bit(1'b1, s);
    clk_bit(1'b1, a);
    chk("mid_rest_nack", a, 1);
    do_stop();

    // Fresh START after reset is recognised again.
    do_start();
    send_byte(8'hEC, a);
    chk("post_addr_ack", a, 0);
    exp_q.push_back({8'h20, 8'h33});
    send_byte(8'h20, a);
    chk("post_reg_ack", a, 0);
    send_byte(8'h33, a);
    chk("post_data_ack", a, 0);
    do_stop();
    chk("post_rd_addr", rd_addr, 8'h21);

    chk("wr_queue_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/iic_target.md
IIC_TARGET -- requirements
Module: iic_target

Interface
REQ-001 Parameter: DEV_ADDR, 7'b1110110, 7-bit device address the block answers to.
REQ-002 Parameter: FILTER_LEN, 3, consecutive equal clk samples required before a filtered SCL/SDA level changes.
REQ-003 Port: clk  in  1  system clock.
REQ-004 Port: rst  in  1  reset, synchronous, active-low.
REQ-005 Port: scl_in  in  1  raw bus clock (asynchronous).
REQ-006 Port: sda_in  in  1  raw bus data (asynchronous).
REQ-007 Port: sda_oe  out  1  1 = pull SDA low (open-drain); 0 = release.
REQ-008 Port: wr_en  out  1  single-clk register write strobe.
REQ-009 Port: wr_addr  out  8  register address for wr_en.
REQ-010 Port: wr_data  out  8  register data for wr_en.
REQ-011 Port: rd_addr  out  8  current register pointer, for read lookup.
REQ-012 Port: rd_data  in  8  register contents at rd_addr, combinational from the owner.
REQ-013 Port: busy  out  1  high from an addressed START until STOP or NACK-ignore.

Function
REQ-014 scl_in/sda_in SHALL pass through 2-FF sync, then a FILTER_LEN filter; all decisions use filtered levels only.
REQ-015 START = filtered SDA 1->0 while SCL high; STOP = SDA 0->1 while SCL high; both detected in the clk after the filtered edge.
REQ-016 Data SHALL be sampled on filtered SCL rise, MSB first; SDA SHALL change only on the clk after filtered SCL fall.
REQ-017 States: IDLE, ADDR, ADDR_ACK, REG, REG_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, IGNORE.
REQ-018 IDLE->ADDR on START; ADDR collects 8 bits; match of bits[7:1] with DEV_ADDR -> ADDR_ACK, else -> IGNORE (sda_oe stays 0).
REQ-019 ACK: sda_oe=1 from SCL fall after 8th bit until next SCL fall (9th clock), then 0.
REQ-020 ADDR_ACK with R/W=0 -> REG; REG byte loads pointer; REG_ACK -> WDATA; each WDATA byte -> WDATA_ACK -> WDATA.
REQ-021 wr_en SHALL pulse exactly one clk, the clk after the 8th WDATA bit is sampled, with wr_addr=pointer, wr_data=byte; pointer then increments, 8'hFF wraps to 8'h00.
REQ-022 ADDR_ACK with R/W=1 -> RDATA: rd_data captured into shift register at the SCL fall ending the ACK; bits driven as sda_oe=~bit; pointer increments after each byte.
REQ-023 RDATA_ACK samples master bit on 9th SCL rise: 0 (ACK) -> RDATA next byte; 1 (NACK) -> IGNORE, sda_oe=0.
REQ-024 IGNORE holds sda_oe=0 until START (->ADDR) or STOP (->IDLE).
REQ-025 START in any state = repeated start: -> ADDR, bit counter cleared, pointer retained, sda_oe=0.
REQ-026 STOP in any state -> IDLE, sda_oe=0, partial byte discarded (no wr_en).
REQ-027 busy=1 in ADDR_ACK through RDATA_ACK; 0 in IDLE, ADDR, IGNORE.

Reset
REQ-028 rst=0 at any clk edge, including mid-byte: state IDLE, sda_oe=0, wr_en=0, wr_addr=0, wr_data=0, rd_addr=0, busy=0, filters preset to 1.
REQ-029 After release, a transaction SHALL be recognised only after a fresh START.

Configuration
REQ-030 Macro IIC_TARGET_READ_EN: defined -> read path (REQ-022/023) present; undefined -> address with R/W=1 is NACKed (-> IGNORE), RDATA/RDATA_ACK absent, rd_data unused, rd_addr still tracks pointer.

Structure
REQ-031 Package iic_pkg SHALL hold typedef iic_tgt_state_t and shared constants (ACK=0, NACK=1, byte width 8).
REQ-032 Sub-module iic_line_filter (sync + filter + rise/fall pulses), instantiated once for SCL, once for SDA.

Verification
REQ-033 START, 0xEC, 0x41, 0x10, STOP -> ACK on 3 bytes; one wr_en with wr_addr=0x41, wr_data=0x10.
REQ-034 START, 0xEC, 0x98, 0x03, 0xE0, STOP -> wr_en (0x98,0x03) then (0x99,0xE0); rd_addr=0x9A after.
REQ-035 START, 0xEE, 0x55 -> no ACK (sda_oe never 1), no wr_en, busy=0; STOP -> IDLE.
REQ-036 Pointer 0x9A, repeated START, 0xED, rd_data=0xE0, master NACK -> bits 1110_0000 on SDA, then released; rd_addr=0x9B (without macro: 0xED NACKed).
REQ-037 Pointer 0xFF, write 0xAA, 0xBB -> writes at 0xFF then 0x00.
REQ-038 rst=0 after 4 data bits of WDATA -> sda_oe=0, no wr_en; 1-clk SDA glitch (FILTER_LEN=3) -> no START detected.
